// File: rtl/sc_bitstream_decoder_pkg.sv
// Shared stochastic-computing definitions: decoder state type, clog2 helper and
// the default stream length / probability width used by the generators too.
package sc_pkg;

    localparam int SC_DEFAULT_LEN = 256;
    localparam int SC_PROB_W      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sc_dec_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sc_bitstream_decoder_if.sv
// Bitstream input, window control and result handshake of the SC decoder.
interface sc_bitstream_decoder_if
    import sc_pkg::*;
#(
    parameter int CNT_W  = clog2(SC_DEFAULT_LEN + 1),
    parameter int PROB_W = SC_PROB_W
);
    logic              start;
    logic              abort;
    logic              bit_in;
    logic              bit_valid;
    logic              busy;
    logic              result_valid;
    logic              result_ack;
    logic [CNT_W-1:0]  ones_count;
    logic [PROB_W-1:0] prob;

    modport master (
        output start, abort, bit_in, bit_valid, result_ack,
        input  busy, result_valid, ones_count, prob
    );

    modport slave (
        input  start, abort, bit_in, bit_valid, result_ack,
        output busy, result_valid, ones_count, prob
    );
endinterface

// File: rtl/sc_bitstream_decoder_ones_counter.sv
// Window sample counter plus ones accumulator; tc_o flags the final sample slot.
module sc_ones_counter #(
    parameter int STREAM_LEN = 256,
    parameter int CNT_W      = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [CNT_W-1:0] ones_o,
    output logic             tc_o
);
    logic [CNT_W-1:0] samples_q, samples_d;
    logic [CNT_W-1:0] ones_q, ones_d;

    always_comb begin
        samples_d = samples_q;
        ones_d    = ones_q;
        if (clr_i) begin
            samples_d = '0;
            ones_d    = '0;
        end else if (en_i) begin
            samples_d = samples_q + CNT_W'(1);
            ones_d    = ones_q + CNT_W'(bit_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_q <= '0;
            ones_q    <= '0;
        end else begin
            samples_q <= samples_d;
            ones_q    <= ones_d;
        end
    end

    assign ones_o = ones_q;
    assign tc_o   = (samples_q == CNT_W'(STREAM_LEN - 1));
endmodule

// File: rtl/sc_bitstream_decoder.sv
// Stochastic-to-binary decoder: counts ones over a STREAM_LEN-sample window and
// holds count plus saturated probability behind a valid/ack handshake.
module sc_bitstream_decoder
    import sc_pkg::*;
#(
    parameter int STREAM_LEN = SC_DEFAULT_LEN,
    parameter int CNT_W      = clog2(STREAM_LEN + 1),
    parameter int PROB_W     = SC_PROB_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    sc_bitstream_decoder_if.slave  bus
);
    // Scaling n*2^PROB_W/STREAM_LEN as n*MULT >> SH; SH = 2*CNT_W keeps the
    // rounded-up reciprocal exact for every n in 0..STREAM_LEN.
    localparam int SH = 2 * CNT_W;
    localparam int NW = PROB_W + SH;
    localparam int MW = NW + 1;
    localparam int PW = MW + CNT_W;
    localparam logic [MW-1:0] SCALE_ONE  = MW'(1) << NW;
    localparam logic [MW-1:0] SCALE_MULT = (SCALE_ONE + MW'(STREAM_LEN - 1)) / MW'(STREAM_LEN);
    localparam logic [PW-1:0] PROB_MAX   = PW'((1 << PROB_W) - 1);

    function automatic logic [PROB_W-1:0] scale_sat(input logic [CNT_W-1:0] n);
        logic [PW-1:0] prod;
        logic [PW-1:0] q;
        prod = PW'(n) * PW'(SCALE_MULT);
        q    = prod >> SH;
        if (q > PROB_MAX) return '1;
        return q[PROB_W-1:0];
    endfunction

    sc_dec_state_t     state_q, state_d;
    logic              clr, en, load, tc;
    logic [CNT_W-1:0]  ones_cnt, ones_final;
    logic [CNT_W-1:0]  ones_q, ones_d;
    logic [PROB_W-1:0] prob_q, prob_d;

    sc_ones_counter #(
        .STREAM_LEN(STREAM_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (en),
        .bit_i (bus.bit_in),
        .ones_o(ones_cnt),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        en      = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COUNT;
                    clr     = 1'b1;
                end
            end
            COUNT: begin
                // abort wins over a coincident final sample
                if (bus.abort) begin
                    state_d = IDLE;
                    clr     = 1'b1;
                end else if (bus.bit_valid) begin
                    en = 1'b1;
                    if (tc) begin
                        load    = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.result_ack) begin
                    state_d = bus.start ? COUNT : IDLE;
                    clr     = bus.start;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ones_final = ones_cnt + CNT_W'(bus.bit_in);
    assign ones_d     = load ? ones_final : ones_q;
    assign prob_d     = load ? scale_sat(ones_final) : prob_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ones_q  <= '0;
            prob_q  <= '0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            prob_q  <= prob_d;
        end
    end

    assign bus.busy         = (state_q == COUNT);
    assign bus.result_valid = (state_q == DONE);
    assign bus.ones_count   = ones_q;
    assign bus.prob         = prob_q;
endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// Self-checking bench for sc_bitstream_decoder: a 256-sample and a 200-sample
// instance checked against a sample-counting reference model.
module tb_sc_bitstream_decoder;
    localparam int LEN_A = 256;
    localparam int LEN_B = 200;

    logic clk;
    logic rst_n;
    logic rst_n_b;
    int   total;
    int   bad;

    sc_bitstream_decoder_if #(.CNT_W(9), .PROB_W(8)) ifa ();
    sc_bitstream_decoder_if #(.CNT_W(8), .PROB_W(8)) ifb ();

    sc_bitstream_decoder #(.STREAM_LEN(LEN_A), .CNT_W(9), .PROB_W(8)) u_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifa)
    );

    sc_bitstream_decoder #(.STREAM_LEN(LEN_B), .CNT_W(8), .PROB_W(8)) u_b (
        .clk  (clk),
        .rst_n(rst_n_b),
        .bus  (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit b, input logic st, input logic ab, input logic bi,
                       input logic bv, input logic ak);
        if (b) begin
            ifb.start = st; ifb.abort = ab; ifb.bit_in = bi; ifb.bit_valid = bv; ifb.result_ack = ak;
        end else begin
            ifa.start = st; ifa.abort = ab; ifa.bit_in = bi; ifa.bit_valid = bv; ifa.result_ack = ak;
        end
    endtask

    function automatic logic [31:0] o_ones(input bit b);
        return b ? 32'(ifb.ones_count) : 32'(ifa.ones_count);
    endfunction
    function automatic logic [31:0] o_prob(input bit b);
        return b ? 32'(ifb.prob) : 32'(ifa.prob);
    endfunction
    function automatic logic o_busy(input bit b);
        return b ? ifb.busy : ifa.busy;
    endfunction
    function automatic logic o_rv(input bit b);
        return b ? ifb.result_valid : ifa.result_valid;
    endfunction

    // Probability as the fraction of ones in the window, scaled to 8 bits.
    function automatic int ref_prob(input int ones, input int len);
        int p;
        p = (ones * 256) / len;
        return (p > 255) ? 255 : p;
    endfunction

    // Feeds one full window and checks the result against the counted samples.
    // mode: 0 ones, 1 alternating, 2 LFSR vs threshold, 3 first half ones, 4 random, 5 zeros
    task automatic run_window(input bit b, input bit do_start, input int mode,
                              input int stall, input int thr, input string tag);
        int         len, got, ones, cyc, seq_err;
        logic       bi, bv;
        logic [7:0] lfsr;
        len = b ? LEN_B : LEN_A;
        got = 0; ones = 0; cyc = 0; seq_err = 0;
        lfsr = 8'($urandom_range(1, 255));
        if (do_start) begin
            drv(b, 1, 0, 0, 0, 0);
            tick();
        end
        while (got < len && cyc < 4 * len) begin
            bv = (stall == 0) || ((cyc % stall) != stall - 1);
            case (mode)
                0: bi = 1'b1;
                1: bi = (got % 2 == 0);
                2: begin
                    bi   = (int'(lfsr) < thr);
                    lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                end
                3: bi = (got < len / 2);
                5: bi = 1'b0;
                default: bi = 1'($urandom_range(0, 1));
            endcase
            drv(b, 0, 0, bi, bv, 0);
            if (o_busy(b) !== 1'b1 || o_rv(b) !== 1'b0) seq_err++;
            tick();
            cyc++;
            if (bv) begin
                got++;
                ones += int'(bi);
            end
        end
        drv(b, 0, 0, 0, 0, 0);
        check({tag, "_len"}, got, len);
        check({tag, "_busy_during"}, seq_err, 0);
        check({tag, "_rv"}, o_rv(b), 1);
        check({tag, "_busy_done"}, o_busy(b), 0);
        check({tag, "_ones"}, o_ones(b), ones);
        check({tag, "_prob"}, o_prob(b), ref_prob(ones, len));
    endtask

    task automatic ack_idle(input bit b, input string tag);
        drv(b, 0, 0, 0, 0, 1);
        tick();
        drv(b, 0, 0, 0, 0, 0);
        check({tag, "_ack_rv"}, o_rv(b), 0);
        check({tag, "_ack_busy"}, o_busy(b), 0);
    endtask

    initial begin
        int          flag;
        logic [31:0] prev_ones, prev_prob;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        rst_n_b = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0);
        #2;
        check("rst_busy", o_busy(0), 0);
        check("rst_rv", o_rv(0), 0);
        check("rst_ones", o_ones(0), 0);
        check("rst_prob", o_prob(0), 0);
        tick();
        tick();
        rst_n = 1'b1;
        rst_n_b = 1'b1;
        tick();

        run_window(0, 1, 0, 0, 0, "all_ones");
        check("all_ones_cnt_abs", o_ones(0), 256);
        check("all_ones_prob_abs", o_prob(0), 255);
        ack_idle(0, "all_ones");

        run_window(0, 1, 1, 3, 0, "alt");
        check("alt_cnt_abs", o_ones(0), 128);
        ack_idle(0, "alt");

        run_window(0, 1, 5, 0, 0, "zeros");
        ack_idle(0, "zeros");

        run_window(0, 1, 2, 0, int'($urandom_range(30, 220)), "lfsr");
        ack_idle(0, "lfsr");

        // Abort at sample 100: previous result held, no result produced.
        prev_ones = o_ones(0);
        prev_prob = o_prob(0);
        drv(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 100; i++) begin
            drv(0, 0, 0, 1'($urandom_range(0, 1)), 1, 0);
            tick();
        end
        drv(0, 0, 1, 1, 1, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        check("abort_busy", o_busy(0), 0);
        check("abort_rv", o_rv(0), 0);
        check("abort_hold_ones", o_ones(0), prev_ones);
        check("abort_hold_prob", o_prob(0), prev_prob);
        flag = 0;
        for (int i = 0; i < 5; i++) begin
            drv(0, 0, 0, 1, 1, 0);
            tick();
            if (o_rv(0) !== 1'b0 || o_busy(0) !== 1'b0) flag++;
        end
        check("idle_drop", flag, 0);
        run_window(0, 1, 4, 0, 0, "fresh");
        ack_idle(0, "fresh");

        // Abort coincident with the final sample.
        drv(0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < LEN_A - 1; i++) begin
            drv(0, 0, 0, 1, 1, 0);
            tick();
        end
        drv(0, 0, 1, 1, 1, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        check("abort_last_rv", o_rv(0), 0);
        check("abort_last_busy", o_busy(0), 0);

        // DONE holds through start/abort/samples without ack.
        run_window(0, 1, 4, 0, 0, "hold_pre");
        prev_ones = o_ones(0);
        prev_prob = o_prob(0);
        flag = 0;
        for (int i = 0; i < 10; i++) begin
            drv(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            tick();
            if (o_ones(0) !== prev_ones || o_prob(0) !== prev_prob ||
                o_rv(0) !== 1'b1 || o_busy(0) !== 1'b0) flag++;
        end
        check("done_hold", flag, 0);
        drv(0, 1, 0, 0, 0, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        check("b2b_busy", o_busy(0), 1);
        check("b2b_rv", o_rv(0), 0);
        run_window(0, 0, 3, 0, 0, "b2b");
        check("b2b_cnt_abs", o_ones(0), 128);
        ack_idle(0, "b2b");

        // 200-sample instance: non-power-of-two scaling.
        run_window(1, 1, 3, 0, 0, "b_half");
        check("b_half_cnt_abs", o_ones(1), 100);
        check("b_half_prob_abs", o_prob(1), 128);
        ack_idle(1, "b_half");
        run_window(1, 1, 0, 0, 0, "b_full");
        check("b_full_cnt_abs", o_ones(1), 200);
        check("b_full_prob_abs", o_prob(1), 255);
        ack_idle(1, "b_full");
        run_window(1, 1, 4, 4, 0, "b_rand");
        ack_idle(1, "b_rand");

        // Asynchronous reset mid-window clears outputs between clock edges.
        drv(1, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 50; i++) begin
            drv(1, 0, 0, 1, 1, 0);
            tick();
        end
        #2;
        rst_n_b = 1'b0;
        #1;
        check("arst_busy", o_busy(1), 0);
        check("arst_rv", o_rv(1), 0);
        check("arst_ones", o_ones(1), 0);
        check("arst_prob", o_prob(1), 0);
        drv(1, 0, 0, 0, 0, 0);
        tick();
        rst_n_b = 1'b1;
        tick();
        check("arst_after_busy", o_busy(1), 0);
        run_window(1, 1, 1, 0, 0, "b_after_rst");
        check("b_after_rst_cnt_abs", o_ones(1), 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
